// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory port arbiter.
// Holds the arbiter state encoding, the requester side encoding and the
// default widths that the cache controllers also use.
package mem_arb_pkg;

  localparam int unsigned DefMemLatency = 4;
  localparam int unsigned DefAddrW      = 16;
  localparam int unsigned DefBlockW     = 64;
  localparam int unsigned DefCntW       = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIRead,
    StDRead,
    StDWrite,
    StDone
  } arb_state_e;

  typedef enum logic {
    SideI = 1'b0,
    SideD = 1'b1
  } side_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the per-side transfer statistics.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : add one this cycle (ignored once the count is all-ones)
//   count        : current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// I-cache (block reads) and D-cache (block reads and evictions).
// Ports:
//   clk, reset_n                       : clock, asynchronous active-low reset
//   i_req_read, i_req_addr             : I-side read request (level)
//   i_rdata, i_done                    : I-side fill data and completion pulse
//   d_req_read, d_req_write, d_req_addr,
//   d_wdata                            : D-side read / write request (level)
//   d_rdata, d_done                    : D-side fill data and completion pulse
//   mem_addr, mem_read, mem_write,
//   mem_wdata, mem_rdata               : shared memory port
//   busy                               : a transfer is in progress
//   i_xfer_cnt, d_xfer_cnt             : saturating grant counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DefMemLatency,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned BLOCK_W     = DefBlockW,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_req_read,
  input  logic [ADDR_W-1:0]  i_req_addr,
  output logic [BLOCK_W-1:0] i_rdata,
  output logic               i_done,
  input  logic               d_req_read,
  input  logic               d_req_write,
  input  logic [ADDR_W-1:0]  d_req_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               d_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic               busy,
  output logic [CNT_W-1:0]   i_xfer_cnt,
  output logic [CNT_W-1:0]   d_xfer_cnt
);

  localparam int unsigned LatW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(MEM_LATENCY - 1);

  arb_state_e         state_q, state_d;
  side_e              last_grant_q, last_grant_d;
  logic [LatW-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
  logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
  logic               i_inc, d_inc;
  logic               i_pend, d_pend, pick_d;

  // Block addresses are word-aligned; the low bits are dropped on grant.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr[1:0], d_req_addr[1:0]};

  assign i_pend = i_req_read;
  assign d_pend = d_req_read | d_req_write;
  // On conflict, serve the side that did not win last time.
  assign pick_d = d_pend & (~i_pend | (last_grant_q == SideI));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_inc        = 1'b0;
    d_inc        = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_d) begin
          // A pending write is serviced before a pending read.
          state_d      = d_req_write ? StDWrite : StDRead;
          last_grant_d = SideD;
          addr_d       = {d_req_addr[ADDR_W-1:2], 2'b00};
          if (d_req_write) begin
            wdata_d = d_wdata;
          end
          d_inc = 1'b1;
        end else if (i_pend) begin
          state_d      = StIRead;
          last_grant_d = SideI;
          addr_d       = {i_req_addr[ADDR_W-1:2], 2'b00};
          i_inc        = 1'b1;
        end
      end
      StIRead, StDRead, StDWrite: begin
        if (cnt_q == LatLast) begin
          cnt_d   = '0;
          state_d = StDone;
          if (state_q == StIRead) begin
            i_rdata_d = mem_rdata;
          end
          if (state_q == StDRead) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= SideI;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_i_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (i_inc),
    .count  (i_xfer_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_d_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (d_inc),
    .count  (d_xfer_cnt)
  );

  // In DONE, last_grant_q still names the side that owns the transfer.
  assign mem_read  = (state_q == StIRead) || (state_q == StDRead);
  assign mem_write = (state_q == StDWrite);
  assign mem_addr  = (mem_read || mem_write) ? addr_q : '0;
  assign mem_wdata = mem_write ? wdata_q : '0;
  assign i_done    = (state_q == StDone) && (last_grant_q == SideI);
  assign d_done    = (state_q == StDone) && (last_grant_q == SideD);
  assign busy      = (state_q != StIdle);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req_read, d_req_read, d_req_write;
  logic [15:0] i_req_addr, d_req_addr;
  logic [63:0] d_wdata;
  logic [63:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        i_done, d_done, mem_read, mem_write, busy;
  logic [15:0] mem_addr, i_xfer_cnt, d_xfer_cnt;

  // Small-counter instance for the saturation check.
  logic        s_i_req;
  logic [63:0] s_i_rdata, s_d_rdata, s_mem_wdata;
  logic        s_i_done, s_d_done, s_mem_read, s_mem_write, s_busy;
  logic [15:0] s_mem_addr;
  logic [1:0]  s_i_cnt, s_d_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LATENCY(4), .ADDR_W(16), .BLOCK_W(64), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_read(i_req_read), .i_req_addr(i_req_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req_read(d_req_read), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .i_xfer_cnt(i_xfer_cnt), .d_xfer_cnt(d_xfer_cnt)
  );

  mem_port_arbiter #(
    .MEM_LATENCY(1), .ADDR_W(16), .BLOCK_W(64), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .i_req_read(s_i_req), .i_req_addr(16'h0040), .i_rdata(s_i_rdata), .i_done(s_i_done),
    .d_req_read(1'b0), .d_req_write(1'b0), .d_req_addr(16'h0000),
    .d_wdata(64'h0), .d_rdata(s_d_rdata), .d_done(s_d_done),
    .mem_addr(s_mem_addr), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .mem_wdata(s_mem_wdata), .mem_rdata(64'h0), .busy(s_busy),
    .i_xfer_cnt(s_i_cnt), .d_xfer_cnt(s_d_cnt)
  );

  function automatic logic [63:0] fill(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
  endfunction

  // Memory model: read data is only correct in the 4th strobe cycle.
  logic [2:0] beat;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) beat <= 3'd0;
    else          beat <= (mem_read || mem_write) ? beat + 3'd1 : 3'd0;
  end
  assign mem_rdata = (mem_read && beat == 3'd3) ? fill(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          side_d;
    bit          wr;
    logic [15:0] addr;
    logic [63:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: tracks each transfer on the memory port, scores it at done.
  int          rd_len, wr_len;
  logic [15:0] seen_addr;
  logic [63:0] seen_wdata;
  bit          unstable;
  exp_t        e;

  always @(negedge clk) begin
    if (!reset_n) begin
      rd_len = 0; wr_len = 0; unstable = 0;
    end else begin
      if (mem_read || mem_write) begin
        if (rd_len + wr_len == 0) begin
          seen_addr = mem_addr; seen_wdata = mem_wdata;
        end else if (mem_addr !== seen_addr || mem_wdata !== seen_wdata) begin
          unstable = 1;
        end
        if (mem_read)  rd_len++;
        if (mem_write) wr_len++;
      end
      if (i_done && d_done) begin
        check("done_overlap", 64'(d_done), 64'(1'b0));
      end else if (i_done || d_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(1'b1), 64'(1'b0));
        end else begin
          e = exp_q.pop_front();
          check("done_side", 64'(d_done), 64'(e.side_d));
          check("rd_strobe_cycles", 64'(rd_len), e.wr ? 64'd0 : 64'd4);
          check("wr_strobe_cycles", 64'(wr_len), e.wr ? 64'd4 : 64'd0);
          check("mem_addr", 64'(seen_addr), 64'(e.addr));
          check("mem_wdata", seen_wdata, e.wr ? e.wdata : 64'h0);
          check("port_stable", 64'(unstable), 64'd0);
          if (!e.wr) check("rdata", d_done ? d_rdata : i_rdata, fill(e.addr));
          check("bus_idle_at_done", {60'h0, mem_read, mem_write, |mem_addr, |mem_wdata}, 64'h0);
          check("busy_at_done", 64'(busy), 64'd1);
        end
        rd_len = 0; wr_len = 0; unstable = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Cycles from now until either done is seen; 0 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (i_done || d_done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    reset_n = 1'b0;
    i_req_read = 0; d_req_read = 0; d_req_write = 0; s_i_req = 0;
    i_req_addr = '0; d_req_addr = '0; d_wdata = '0;
    step();
    step();
    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_i_cnt", 64'(i_xfer_cnt), 64'd0);
    check("rst_d_cnt", 64'(d_xfer_cnt), 64'd0);
    check("rst_i_rdata", i_rdata, 64'd0);
    check("rst_done", {62'h0, i_done, d_done}, 64'd0);
    reset_n = 1'b1;
    step();

    // I read alone
    exp_q.push_back('{side_d: 0, wr: 0, addr: 16'h0120, wdata: 64'h0});
    i_req_addr = 16'h0123;
    i_req_read = 1;
    wait_done(lat);
    check("i_latency", 64'(lat), 64'd5);
    check("i_cnt_after_one", 64'(i_xfer_cnt), 64'd1);
    i_req_read = 0;
    step();

    // Simultaneous requests after reset: D, I, D, I
    do_reset();
    exp_q.push_back('{side_d: 1, wr: 0, addr: 16'h0208, wdata: 64'h0});
    exp_q.push_back('{side_d: 0, wr: 0, addr: 16'h0310, wdata: 64'h0});
    exp_q.push_back('{side_d: 1, wr: 0, addr: 16'h0208, wdata: 64'h0});
    exp_q.push_back('{side_d: 0, wr: 0, addr: 16'h0310, wdata: 64'h0});
    d_req_addr = 16'h0209;
    i_req_addr = 16'h0312;
    d_req_read = 1;
    i_req_read = 1;
    for (int t = 0; t < 4; t++) begin
      wait_done(lat);
      check("alt_lat", 64'(lat), (t == 0) ? 64'd5 : 64'd6);
      if (t == 3) begin
        d_req_read = 0;
        i_req_read = 0;
      end
    end
    check("alt_i_cnt", 64'(i_xfer_cnt), 64'd2);
    check("alt_d_cnt", 64'(d_xfer_cnt), 64'd2);
    step();

    // D writeback
    exp_q.push_back('{side_d: 1, wr: 1, addr: 16'h0044, wdata: 64'hDEAD_BEEF_0123_4567});
    d_req_addr = 16'h0047;
    d_wdata = 64'hDEAD_BEEF_0123_4567;
    d_req_write = 1;
    wait_done(lat);
    check("wb_latency", 64'(lat), 64'd5);
    d_req_write = 0;
    step();

    // Write and read together on D: write first, read after write drops
    exp_q.push_back('{side_d: 1, wr: 1, addr: 16'h0050, wdata: 64'h0011_2233_4455_6677});
    exp_q.push_back('{side_d: 1, wr: 0, addr: 16'h0050, wdata: 64'h0});
    d_req_addr = 16'h0052;
    d_wdata = 64'h0011_2233_4455_6677;
    d_req_write = 1;
    d_req_read = 1;
    wait_done(lat);
    check("wr_rd_first_lat", 64'(lat), 64'd5);
    d_req_write = 0;
    wait_done(lat);
    check("wr_rd_second_lat", 64'(lat), 64'd6);
    d_req_read = 0;
    check("wr_rd_d_cnt", 64'(d_xfer_cnt), 64'd5);
    step();

    // Reset in the 2nd cycle of an I read
    i_req_addr = 16'h0123;
    i_req_read = 1;
    step();
    step();
    check("mid_pre_reset_read", 64'(mem_read), 64'd1);
    reset_n = 1'b0;
    i_req_read = 0;
    #1;
    check("mid_mem_read", 64'(mem_read), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_i_cnt", 64'(i_xfer_cnt), 64'd0);
    check("mid_d_cnt", 64'(d_xfer_cnt), 64'd0);
    check("mid_i_rdata", i_rdata, 64'd0);
    check("mid_d_rdata", d_rdata, 64'd0);
    step();
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      step();
      seen = seen | int'(i_done | d_done);
    end
    check("no_done_after_reset", 64'(seen), 64'd0);
    exp_q.push_back('{side_d: 0, wr: 0, addr: 16'h0120, wdata: 64'h0});
    i_req_read = 1;
    wait_done(lat);
    check("reissue_latency", 64'(lat), 64'd5);
    check("reissue_i_cnt", 64'(i_xfer_cnt), 64'd1);
    i_req_read = 0;
    step();

    // Counter saturation on the 2-bit instance
    s_i_req = 1;
    for (int k = 1; k <= 5; k++) begin
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
        step();
        if (s_i_done) begin
          lat = c;
          break;
        end
      end
      if (lat == 0) check("sat_timeout", 64'd1, 64'd0);
      check("sat_i_cnt", 64'(s_i_cnt), (k < 3) ? 64'(k) : 64'd3);
    end
    s_i_req = 0;
    check("sat_d_cnt", 64'(s_d_cnt), 64'd0);
    step();
    step();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one memory port between the I-cache and D-cache miss engines. It accepts block-read requests from the I side and block-read or block-write requests from the D side, and runs one transfer at a time on the shared 64-bit memory port with a fixed latency. Round-robin decides conflicts, so neither side starves. The block sits between both cache controllers and the memory model, and it also keeps per-side transfer counters for performance reporting.

## Interface
- MEM_LATENCY, 4: cycles the memory needs with the request held stable (≥1).
- ADDR_W, 16: address width.
- BLOCK_W, 64: block width (4 words).
- CNT_W, 16: width of the transfer counters.

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- i_req_read  in  1  I-side block-read request, level, held until i_done
- i_req_addr  in  ADDR_W  I-side block address
- i_rdata  out  BLOCK_W  I-side fill data, valid while i_done=1
- i_done  out  1  one-cycle completion pulse to the I side
- d_req_read  in  1  D-side block-read request, level
- d_req_write  in  1  D-side block-write (eviction) request, level
- d_req_addr  in  ADDR_W  D-side block address
- d_wdata  in  BLOCK_W  D-side eviction data
- d_rdata  out  BLOCK_W  D-side fill data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse to the D side
- mem_addr  out  ADDR_W  memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_wdata  out  BLOCK_W  memory write data
- mem_rdata  in  BLOCK_W  memory read data, valid in the last latency cycle
- busy  out  1  a transfer is in progress (state ≠ IDLE)
- i_xfer_cnt  out  CNT_W  number of I grants, saturating
- d_xfer_cnt  out  CNT_W  number of D grants, saturating

## Operation
- The state machine has five states: IDLE, I_READ, D_READ, D_WRITE, DONE.
- **IDLE:** the block samples the requests. The D side is pending if d_req_read or d_req_write is high. The I side is pending if i_req_read is high.
  - Only one side pending: grant that side.
  - Both sides pending: grant the side opposite last_grant. last_grant resets to I, so the first conflict goes to D.
  - On grant, the block updates last_grant and latches the address as {addr[ADDR_W-1:2],2'b00}. For a D write it also latches d_wdata.
  - On grant, it increments that side's transfer counter, saturating at all-ones.
- **D side with both d_req_write and d_req_read high:** D_WRITE is serviced first. The read is a new request after d_done.
- **I_READ / D_READ / D_WRITE:**
  - mem_read, or mem_write for D_WRITE, is held at 1 together with the latched mem_addr and mem_wdata for MEM_LATENCY cycles. cnt counts from 0 to MEM_LATENCY-1.
  - At cnt=MEM_LATENCY-1, a read registers mem_rdata into i_rdata or d_rdata.
  - The state then moves to DONE.
- **DONE:**
  - The granted side's done output is 1 for exactly one cycle, and the requests are not sampled.
  - The next state is IDLE.
  - The requester must drop or change its request in the cycle after done.
- **Outside transfers:** mem_read, mem_write, mem_addr and mem_wdata are 0. i_rdata and d_rdata hold their last value.
- **Reset, including mid-transfer:**
  - State goes to IDLE, cnt to 0 and last_grant to I.
  - All outputs go to 0, including both counters and both rdata registers.
  - The in-flight transfer is abandoned and no done is issued. The requester reissues the request.
- **Request dropped mid-transfer:** this is a protocol violation. The transfer completes anyway and done still pulses.

## Timing
- A request high in cycle n, with the block IDLE, gets its memory strobe in cycles n+1 through n+MEM_LATENCY.
- done and valid rdata follow in cycle n+MEM_LATENCY+1.
- The earliest next grant is at the end of cycle n+MEM_LATENCY+2.
- Throughput is one transfer per MEM_LATENCY+2 cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- A request that arrives during a transfer waits. Under continuous contention the two sides strictly alternate.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, I_READ, D_READ, D_WRITE, DONE);
  - the side encoding (SIDE_I=0, SIDE_D=1);
  - the default widths, shared with the cache.
- One sub-module, sat_counter (parameter CNT_W; ports clk, reset_n, inc, count), is instantiated twice for the transfer counters.

## Test plan
- **I read alone:** i_req_read=1, addr 0x0123, MEM_LATENCY=4.
  - Required: mem_addr=0x0120 and mem_read=1 for exactly 4 cycles.
  - Required: i_done pulses 5 cycles after the request, with i_rdata=mem_rdata as sampled in the 4th cycle, and i_xfer_cnt=1.
- **Simultaneous requests after reset:** both sides request reads in the same cycle.
  - Required: D is granted first, then I.
  - Required: with both held continuously, grants alternate D, I, D, I over 4 transfers, and d_done and i_done never overlap.
- **D writeback:** d_req_write=1, addr 0x0047, d_wdata=0xDEAD_BEEF_0123_4567.
  - Required: mem_write=1 for 4 cycles with mem_addr=0x0044 and that data.
  - Required: d_done pulses once and mem_read stays 0 throughout.
- **Write plus read on the D side:** d_req_write and d_req_read both high.
  - Required: a write transfer, d_done, then a read transfer granted after the requester drops the write.
- **Reset mid-transfer:** reset_n low in the 2nd cycle of an I read.
  - Required: mem_read=0, busy=0, counters 0 and no i_done.
  - Required: a reissued request completes normally.
- **Counter saturation:** i_xfer_cnt is forced to 0xFFFE before 3 more I grants.
  - Required: the count reads 0xFFFF and stays there.
